// File: rtl/sram_tiled_wrapper_pkg.sv
// Shared types and sizing helpers for the tiled SRAM wrapper.
package sram_tiled_pkg;

  typedef enum logic {CLEAR, RUN} state_e;

  localparam int RD_LAT = 2;

  function automatic int num_rows(input int addr_w, input int macro_addr_w);
    return (addr_w >= macro_addr_w) ? (1 << (addr_w - macro_addr_w)) : 1;
  endfunction

  function automatic int num_cols(input int data_w, input int macro_data_w);
    return data_w / macro_data_w;
  endfunction

endpackage

// File: rtl/sram_tiled_wrapper_if.sv
// Request/response bundle between a requester and the tiled SRAM wrapper.
interface sram_tiled_wrapper_if #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int NUM_COLS = 2
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wmode;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [NUM_COLS-1:0] req_wmask;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                init_done;

  modport master (
    output req_valid, req_wmode, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_wmode, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_tiled_wrapper_tile.sv
// One macro site. sram1rw_macro is a behavioural stand-in for the hard cell;
// the macro generation flow swaps the cell name inside sram_tile only.
module sram1rw_macro #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          csb,
  input  logic          web,
  input  logic          oeb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (!csb) begin
      if (!web)      mem[addr] <= din;
      else if (!oeb) dout      <= mem[addr];
    end
  end
endmodule

module sram_tile #(
  parameter int MACRO_ADDR_W = 4,
  parameter int MACRO_DATA_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_csb,
  input  logic                    i_web,
  input  logic                    i_oeb,
  input  logic [MACRO_ADDR_W-1:0] i_addr,
  input  logic [MACRO_DATA_W-1:0] i_din,
  output logic [MACRO_DATA_W-1:0] o_dout
);
  sram1rw_macro #(.AW(MACRO_ADDR_W), .DW(MACRO_DATA_W)) u_macro (
    .clk  (i_clk),
    .csb  (i_csb),
    .web  (i_web),
    .oeb  (i_oeb),
    .addr (i_addr),
    .din  (i_din),
    .dout (o_dout)
  );
endmodule

// File: rtl/sram_tiled_wrapper.sv
// Logical 2^ADDR_W x DATA_W memory built from a NUM_ROWS x NUM_COLS macro grid,
// with valid/ready requests, per-column write mask and optional zero-fill.
module sram_tiled_wrapper
  import sram_tiled_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int MACRO_ADDR_W = 4,
  parameter int MACRO_DATA_W = 16,
  parameter bit INIT_ZERO    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sram_tiled_wrapper_if.slave bus
);
  localparam int NUM_ROWS = num_rows(ADDR_W, MACRO_ADDR_W);
  localparam int NUM_COLS = num_cols(DATA_W, MACRO_DATA_W);
  localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  if (ADDR_W < MACRO_ADDR_W) begin : g_bad_addr
    $error("sram_tiled_wrapper: ADDR_W must be >= MACRO_ADDR_W");
  end
  if ((DATA_W % MACRO_DATA_W) != 0) begin : g_bad_data
    $error("sram_tiled_wrapper: DATA_W must be a multiple of MACRO_DATA_W");
  end

  state_e                              r_state;
  logic [MACRO_ADDR_W-1:0]             r_clr_cnt;
  logic                                r_ready;
  logic                                r_init_done;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]   r_csb;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]   r_web;
  logic [NUM_ROWS-1:0]                 r_oeb;
  logic [MACRO_ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]                   r_wdata;
  logic [RD_LAT-1:0]                   r_vld_pipe;
  logic [RD_LAT-1:0][ROW_W-1:0]        r_row_pipe;
  logic                                r_rsp_valid;
  logic [DATA_W-1:0]                   r_rsp_rdata;

  logic [NUM_ROWS-1:0][DATA_W-1:0]     w_dout;
  logic                                w_accept;
  logic                                w_rd_acc;
  logic [ROW_W-1:0]                    w_row;
  logic [MACRO_ADDR_W-1:0]             w_maddr;

  // Shift form yields a constant-0 row when the grid is a single row deep.
  assign w_row    = ROW_W'(bus.req_addr >> MACRO_ADDR_W);
  assign w_maddr  = bus.req_addr[MACRO_ADDR_W-1:0];
  assign w_accept = bus.req_valid && r_ready;
  assign w_rd_acc = w_accept && !bus.req_wmode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_ZERO ? CLEAR : RUN;
      r_clr_cnt   <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_csb       <= '1;
      r_web       <= '1;
      r_oeb       <= '1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_vld_pipe  <= '0;
      r_row_pipe  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_csb <= '1;
      r_web <= '1;
      r_oeb <= '1;
      case (r_state)
        CLEAR: begin
          // Every macro writes zero at the same word each cycle.
          r_csb     <= '0;
          r_web     <= '0;
          r_addr    <= r_clr_cnt;
          r_wdata   <= '0;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state     <= RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        RUN: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
          if (w_accept) begin
            r_addr  <= w_maddr;
            r_wdata <= bus.req_wdata;
            if (bus.req_wmode) begin
              r_csb[w_row] <= ~bus.req_wmask;
              r_web[w_row] <= ~bus.req_wmask;
            end else begin
              r_csb[w_row] <= '0;
              r_oeb[w_row] <= 1'b0;
            end
          end
        end
      endcase

      r_vld_pipe  <= {r_vld_pipe[RD_LAT-2:0], w_rd_acc};
      r_row_pipe  <= {r_row_pipe[RD_LAT-2:0], w_row};
      r_rsp_valid <= r_vld_pipe[RD_LAT-1];
      if (r_vld_pipe[RD_LAT-1]) r_rsp_rdata <= w_dout[r_row_pipe[RD_LAT-1]];
    end
  end

  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      sram_tile #(
        .MACRO_ADDR_W (MACRO_ADDR_W),
        .MACRO_DATA_W (MACRO_DATA_W)
      ) u_tile (
        .i_clk  (clk),
        .i_csb  (r_csb[gr][gc]),
        .i_web  (r_web[gr][gc]),
        .i_oeb  (r_oeb[gr]),
        .i_addr (r_addr),
        .i_din  (r_wdata[gc*MACRO_DATA_W +: MACRO_DATA_W]),
        .o_dout (w_dout[gr][gc*MACRO_DATA_W +: MACRO_DATA_W])
      );
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.init_done = r_init_done;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/sram_tiled_wrapper.md
Name: sram_tiled_wrapper

Overview:
- Parametrised single-port RW SRAM wrapper that builds a logical memory of 2^ADDR_W x DATA_W from a grid of hard SRAM1RW macros.
- Grid is NUM_ROWS deep x NUM_COLS wide; each macro is 2^MACRO_ADDR_W x MACRO_DATA_W.
- Adds three things over the single-macro wrapper: a valid/ready request handshake, per-column write masking, and an optional post-reset zero-fill state machine.
- Sits between the ASIC-DSE test harness/accelerator datapath and the generated macro instances.

Parameters:
ADDR_W, 6, logical address width; depth = 2^ADDR_W
DATA_W, 32, logical data width
MACRO_ADDR_W, 4, address width of one macro
MACRO_DATA_W, 16, data width of one macro
INIT_ZERO, 1, 1 = zero-fill all macros after reset before accepting requests
Derived: NUM_ROWS = 2^(ADDR_W-MACRO_ADDR_W); NUM_COLS = DATA_W/MACRO_DATA_W
Legal configurations: ADDR_W >= MACRO_ADDR_W and DATA_W % MACRO_DATA_W == 0. Violations are caught by elaboration-time assertions.

Ports:
clk  input  1  single clock; all flops and all macro CE pins
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  wrapper can accept a request this cycle
req_wmode  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_wmask  input  NUM_COLS  per-column write enable; ignored on reads
rsp_valid  output  1  read data valid, one-cycle pulse
rsp_rdata  output  DATA_W  read data
init_done  output  1  high once the wrapper is ready for traffic

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - All macro CSB/OEB/WEB registers are 1 (deselected); the address register is 0.
  - The read-pipe valid and row-select registers are 0.
- Address split:
  - row = req_addr[ADDR_W-1:MACRO_ADDR_W], macro address = req_addr[MACRO_ADDR_W-1:0].
  - When NUM_ROWS = 1, row is a constant 0.
- FSM states: CLEAR, RUN.
  - On rst the FSM enters CLEAR if INIT_ZERO=1, otherwise RUN.
  - CLEAR: a counter walks 0 .. 2^MACRO_ADDR_W-1 and writes 0 to every macro at once (all rows, all columns).
  - CLEAR -> RUN on the cycle the counter reaches its last value, so CLEAR lasts exactly 2^MACRO_ADDR_W cycles.
  - RUN: req_ready=1 and init_done=1, held until the next rst.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. Nothing is accepted in CLEAR.
- Control registering: on accept, the control, address and data registers load.
  - Only the addressed row is enabled: CSB=0.
  - Write: WEB=0 only for columns whose wmask bit is 1. Other columns get CSB=1; an all-zero mask is a no-op write.
  - Read: OEB=0, WEB=1, all columns of the row enabled.
  - In cycles with no accept, every macro is deselected.
- Read latency is fixed at 2 cycles.
  - Accept at edge k; the macro samples at edge k+1; the output register captures the row-selected data at edge k+2.
  - rsp_valid is high for the single cycle after edge k+2.
  - The row select is pipelined alongside the request to drive the output mux.
- rsp_rdata holds its last value when rsp_valid=0.
- Throughput: one request per cycle, with any mix of reads and writes.
- No response backpressure: the consumer must sink every rsp_valid pulse.
- Ordering:
  - A write accepted at edge k followed by a read of the same address at edge k+1 returns the new data.
  - Masked-off columns return their old contents.
- Reset mid-operation: in-flight reads are dropped and rsp_valid=0 in the cycle after rst. If INIT_ZERO=1, the clear restarts from address 0.
- Boundaries:
  - The address covers the full depth, so there is no out-of-range case.
  - The top address 2^ADDR_W-1 maps to the last row and the last macro word.

Decomposition:
- Package sram_tiled_pkg:
  - state enum (CLEAR, RUN);
  - functions num_rows(ADDR_W, MACRO_ADDR_W) and num_cols(DATA_W, MACRO_DATA_W);
  - constant RD_LAT = 2.
- Sub-module sram_tile: wraps one macro instance with its active-low control pins.
  - Instantiated in a NUM_ROWS x NUM_COLS generate loop.
  - This is the only place that names the macro cell, so the macro auto-generation flow only edits this sub-module.

Test Plan:
1. Defaults, INIT_ZERO=1: deassert rst -> req_ready stays 0 for exactly 16 cycles, then 1. Reads of 0x00, 0x15 and 0x3F return 0x00000000.
2. Write 0x3F=0xDEADBEEF, then back-to-back read 0x3F -> rsp_valid pulses exactly 2 cycles after the read is accepted, with rsp_rdata = 0xDEADBEEF.
3. Write 0x10=0xAAAA5555 with wmask=2'b11, then write 0x10=0x12340000 with wmask=2'b10, then read -> 0x12345555.
4. Row isolation: write 0x05=0x11111111 and 0x15=0x22222222 (same macro address, different rows) -> reads return their own values. Probe confirms only one row has CSB=0 per access.
5. Pipelined reads at 0x00, 0x01, 0x02 on consecutive cycles -> three consecutive rsp_valid cycles with the data in request order.
6. Assert rst for 1 cycle while two reads are in flight -> no rsp_valid afterwards, CLEAR restarts (16 cycles), and data previously written to 0x3F reads back as 0.
